// File: rtl/slow_mem_resp.sv
//------------------------------------------------------------------------------
// Module   : slow_mem_resp
// Purpose  : Fixed-latency line memory responder. A read or write request is
//            accepted, executed after LATENCY cycles and then acknowledged by
//            a single-cycle mem_ready pulse. One cooldown cycle follows each
//            response. Storage holds 2**IDX_W lines of 128 bits.
// Ports    : clk        - clock, all state changes on its rising edge
//            proc_reset - synchronous active-high reset
//            mem_read   - line read request (held until mem_ready)
//            mem_write  - line write request (held until mem_ready)
//            mem_addr   - line address (byte address bits [31:4])
//            mem_wdata  - write line data
//            mem_rdata  - registered read line data
//            mem_ready  - registered one-cycle completion pulse
//            proto_err  - sticky protocol-violation flag
// Options  : SLOW_MEM_PROTO_CHK_EN - build the requester protocol checker;
//            when undefined proto_err is tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module slow_mem_resp #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err
);

    localparam int         DEPTH    = 1 << IDX_W;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_COOL = 2'd3
    } state_t;

    logic [127:0]     storage [DEPTH];
    state_t           state;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] idx_q;
    logic [127:0]     wdata_q;
    logic             write_q;

    logic request;
    logic accept;
    logic finish;

    assign request = mem_read | mem_write;
    // COOL accepts at its closing edge so back-to-back requests lose no cycle
    // beyond the cooldown itself.
    assign accept  = ((state == S_IDLE) || (state == S_COOL)) && request;
    assign finish  = (state == S_BUSY) && (cnt == 8'd0);

    // Address bits above the index only matter to the optional checker.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[27:IDX_W];

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                S_IDLE, S_COOL: begin
                    if (accept) begin
                        idx_q   <= mem_addr[IDX_W-1:0];
                        wdata_q <= mem_wdata;
                        // Simultaneous read and write resolves to a write.
                        write_q <= mem_write;
                        cnt     <= CNT_LOAD;
                        state   <= S_BUSY;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt == 8'd0) begin
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        if (!write_q) begin
                            mem_rdata <= storage[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_COOL;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; a reset edge suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!proc_reset && finish && write_q) begin
            storage[idx_q] <= wdata_q;
        end
    end

`ifdef SLOW_MEM_PROTO_CHK_EN
    logic [27:0] addr_q;
    logic        err_q;
    logic        violation;

    assign violation = ((state == S_IDLE) && mem_read && mem_write) ||
                       ((state == S_BUSY) && ((mem_addr != addr_q) || !request));

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= mem_addr;
            end
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slow_mem_resp.sv
`default_nettype none

module tb_slow_mem_resp;

    logic         clk;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef SLOW_MEM_PROTO_CHK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_5A = {16{8'h5A}};
    localparam logic [127:0] D_C3 = {16{8'hC3}};
    localparam logic [127:0] D_11 = {16{8'h11}};
    localparam logic [127:0] D_EE = {16{8'hEE}};

    slow_mem_resp #(.LATENCY(4), .IDX_W(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        proc_reset = 1'b0;
    endtask

    // Issue a request, hold it until mem_ready, return the latency in edges
    // counted from the accepting edge and the data seen in the RESP cycle.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd, output int lat, output logic [127:0] data);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        @(posedge clk);          // accepting edge
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_ready) break;
        end
        data = mem_rdata;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);          // RESP -> COOL
        #1;
        check("single_pulse", {127'd0, mem_ready}, 128'd0);
        @(posedge clk);          // COOL -> IDLE
    endtask

    int           lat;
    logic [127:0] rd_data;
    logic [10:0]  rdy_trace;
    int           rdy_cnt;

    initial begin
        proc_reset = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_ready", {127'd0, mem_ready}, 128'd0);
        check("rst_rdata", mem_rdata, 128'd0);
        check("rst_proto", {127'd0, proto_err}, 128'd0);

        // Write A5 at 0x10: ready 4 cycles after acceptance, rdata untouched
        txn(1'b0, 1'b1, 28'h10, D_A5, lat, rd_data);
        check("wr_latency", 128'(lat), 128'd4);
        check("wr_rdata_unchanged", rd_data, 128'd0);

        // Read back 0x10, value held afterwards
        txn(1'b1, 1'b0, 28'h10, D_EE, lat, rd_data);
        check("rd_latency", 128'(lat), 128'd4);
        check("rd_data", rd_data, D_A5);
        repeat (3) @(posedge clk);
        #1;
        check("rd_data_held", mem_rdata, D_A5);

        // Request held continuously: pulses at edges 5 and 11 after setup,
        // second acceptance at the edge ending COOL (edge 7)
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'h10;
        rdy_trace = '0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            rdy_trace[i] = mem_ready;
        end
        @(negedge clk);
        mem_read = 1'b0;
        check("held_req_trace", 128'(rdy_trace), 128'h410);
        repeat (2) @(posedge clk);

        // Aliasing: 0x101 and 0x001 share index 1
        txn(1'b0, 1'b1, 28'h101, D_C3, lat, rd_data);
        txn(1'b1, 1'b0, 28'h001, D_EE, lat, rd_data);
        check("alias_data", rd_data, D_C3);

        // Both high: treated as a write
        txn(1'b1, 1'b1, 28'h30, D_5A, lat, rd_data);
        check("both_latency", 128'(lat), 128'd4);
        check("both_proto", {127'd0, proto_err}, {127'd0, PCHK});
        txn(1'b1, 1'b0, 28'h30, D_EE, lat, rd_data);
        check("both_is_write", rd_data, D_5A);

        // Reset mid-write abandons the transaction
        do_reset();
        #1;
        check("rst2_proto", {127'd0, proto_err}, 128'd0);
        txn(1'b0, 1'b1, 28'h20, D_11, lat, rd_data);
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h20;
        mem_wdata = D_EE;
        @(posedge clk);          // accept
        @(posedge clk);          // 2 cycles into the write
        @(negedge clk);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        rdy_cnt = 0;
        @(posedge clk);
        #1;
        rdy_cnt += int'(mem_ready);
        @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            rdy_cnt += int'(mem_ready);
        end
        check("abort_no_ready", 128'(rdy_cnt), 128'd0);
        check("abort_rdata_rst", mem_rdata, 128'd0);
        txn(1'b1, 1'b0, 28'h20, D_EE, lat, rd_data);
        check("abort_no_write", rd_data, D_11);

        // Address change while BUSY
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'h10;
        @(posedge clk);          // accept
        @(negedge clk);
        mem_addr = 28'h11;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) break;
        end
        @(negedge clk);
        mem_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("addr_chg_proto", {127'd0, proto_err}, {127'd0, PCHK});
        do_reset();
        #1;
        check("proto_cleared", {127'd0, proto_err}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
